// File: rtl/key_pkg.sv
// Shared types and constants for the key-event front end behind a 74HC148-style encoder.
package key_pkg;

  localparam int KEY_IDX_W = 3;

  // Reset values match "encoder disabled": GS high, code all ones.
  localparam logic                 SYNC_GS_RST   = 1'b1;
  localparam logic [KEY_IDX_W-1:0] SYNC_CODE_RST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_e;

endpackage

// File: rtl/key_event_fifo_if.sv
// Consumer-side handshake of the key event queue: FWFT head plus pop request.
interface key_event_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                              KeyRead;
  logic                              KeyValid;
  logic [key_pkg::KEY_IDX_W-1:0]     KeyIndex;
  logic [$clog2(FIFO_DEPTH):0]       KeyCount;

  modport master (input KeyRead, output KeyValid, output KeyIndex, output KeyCount);
  modport slave  (output KeyRead, input KeyValid, input KeyIndex, input KeyCount);
endinterface

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// Synchronises and debounces the encoder outputs and queues one key index per stable press.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_IDX_W-1:0] EncDataOut,
  input  logic                 EncGS,
  input  logic                 ClrOvf,
  output logic                 KeyHeld,
  output logic                 Overflow,
  key_event_fifo_if.master     kif
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic                 gs_meta_q, gs_sync_q;
  logic [KEY_IDX_W-1:0] code_meta_q, code_sync_q;
  logic [KEY_IDX_W-1:0] s_idx;

  key_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_IDX_W-1:0] cand_q, cand_d;
  logic                 push_q, push_d;
  logic                 ovf_q, ovf_d;
  logic                 fifo_full, fifo_empty, drop;

  assign s_idx = ~code_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gs_meta_q   <= SYNC_GS_RST;
      gs_sync_q   <= SYNC_GS_RST;
      code_meta_q <= SYNC_CODE_RST;
      code_sync_q <= SYNC_CODE_RST;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      push_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      gs_meta_q   <= EncGS;
      gs_sync_q   <= gs_meta_q;
      code_meta_q <= EncDataOut;
      code_sync_q <= code_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      push_q      <= push_d;
      ovf_q       <= ovf_d;
    end
  end

  // Release is counted from the first synced high sample, so RELEASE_WAIT
  // exits after DEBOUNCE_CYCLES consecutive highs including the entry cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!gs_sync_q) begin
          state_d = ST_PRESS_WAIT;
          cand_d  = s_idx;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (gs_sync_q) begin
          state_d = ST_IDLE;
        end else if (s_idx != cand_q) begin
          cand_d = s_idx;
          cnt_d  = '0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d = ST_HELD;
          push_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (gs_sync_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (s_idx != cand_q) begin
          state_d = ST_PRESS_WAIT;
          cand_d  = s_idx;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!gs_sync_q) begin
          if (s_idx == cand_q) begin
            state_d = ST_HELD;
          end else begin
            state_d = ST_PRESS_WAIT;
            cand_d  = s_idx;
            cnt_d   = '0;
          end
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full FIFO only drops the event when the consumer is not popping this cycle.
  assign drop = push_q & fifo_full & ~kif.KeyRead;

  always_comb begin
    ovf_d = ovf_q;
    if (ClrOvf) ovf_d = 1'b0;
    if (drop)   ovf_d = 1'b1;
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_IDX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .pop_i   (kif.KeyRead),
    .data_i  (cand_q),
    .data_o  (kif.KeyIndex),
    .count_o (kif.KeyCount),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kif.KeyValid = ~fifo_empty;
  assign KeyHeld      = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign Overflow     = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed and randomized key presses checked against a queue model of the event FIFO.
module tb_key_event_fifo;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] EncDataOut = 3'b111;
  logic       EncGS = 1'b1;
  logic       ClrOvf = 1'b0;
  logic       KeyHeld, Overflow;

  key_event_fifo_if #(.FIFO_DEPTH(DEPTH)) kif ();

  key_event_fifo #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .EncDataOut (EncDataOut),
    .EncGS      (EncGS),
    .ClrOvf     (ClrOvf),
    .KeyHeld    (KeyHeld),
    .Overflow   (Overflow),
    .kif        (kif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_q[$];
  bit model_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, ".valid"}, 32'(kif.KeyValid), 32'(model_q.size() != 0));
    chk({tag, ".index"}, 32'(kif.KeyIndex), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
    chk({tag, ".count"}, 32'(kif.KeyCount), 32'(model_q.size()));
    chk({tag, ".ovf"},   32'(Overflow),     32'(model_ovf));
  endtask

  task automatic model_push(input int idx);
    if (model_q.size() < DEPTH) model_q.push_back(idx);
    else model_ovf = 1'b1;
  endtask

  task automatic key_down(input int idx);
    EncGS      = 1'b0;
    EncDataOut = ~3'(idx);
  endtask

  task automatic key_up();
    EncGS      = 1'b1;
    EncDataOut = 3'b111;
  endtask

  task automatic press(input int idx, input int hold);
    key_down(idx);
    tick(hold);
    model_push(idx);
    key_up();
    tick(10);
  endtask

  task automatic pop();
    kif.KeyRead = 1'b1;
    tick(1);
    kif.KeyRead = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic drain();
    while (model_q.size() != 0) pop();
  endtask

  // Edges after the first sampling edge until KeyValid is seen; 0 if it never rises.
  task automatic measure_valid(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (kif.KeyValid === 1'b1) begin
        n = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int idx;
    int n;
    kif.KeyRead = 1'b0;

    tick(3);
    rst_n = 1'b1;
    chk("reset.held", 32'(KeyHeld), 32'd0);
    check_fifo("reset");

    // Clean press of key 5 with latency measurement.
    key_down(5);
    measure_valid(lat);
    chk("clean.latency", lat, D + 3);
    tick(20 - lat - 1);
    model_push(5);
    check_fifo("clean.entry");
    chk("clean.held", 32'(KeyHeld), 32'd1);
    key_up();
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (KeyHeld === 1'b0) begin
        n = k;
        break;
      end
    end
    chk("clean.release_window", 32'((n >= D + 1) && (n <= D + 3)), 32'd1);
    tick(4);
    check_fifo("clean.single");
    drain();

    // Bounce: short low pulses must not produce an event.
    for (int p = 0; p < 2; p++) begin
      key_down(3);
      tick(2);
      key_up();
      tick(2);
    end
    key_down(3);
    tick(2);
    check_fifo("bounce.none");
    tick(12);
    model_push(3);
    check_fifo("bounce.one");
    key_up();
    tick(2);
    key_down(3);
    tick(12);
    check_fifo("bounce.glitch");
    key_up();
    tick(10);
    drain();

    // Higher-priority key added while key 2 is held.
    key_down(2);
    tick(12);
    model_push(2);
    key_down(6);
    tick(12);
    model_push(6);
    key_up();
    tick(10);
    check_fifo("prio.first");
    pop();
    check_fifo("prio.second");
    drain();

    // Overflow with five debounced presses and no reads.
    for (int i = 0; i < 5; i++) press((i * 3 + $urandom_range(0, 2)) % 8, 12);
    check_fifo("ovf.full");
    ClrOvf = 1'b1;
    tick(1);
    ClrOvf = 1'b0;
    model_ovf = 1'b0;
    check_fifo("ovf.clear");

    // Push and pop on the same edge while full.
    idx = $urandom_range(0, 7);
    key_down(idx);
    tick(D + 3);
    kif.KeyRead = 1'b1;
    tick(1);
    kif.KeyRead = 1'b0;
    void'(model_q.pop_front());
    model_push(idx);
    check_fifo("fullpp");
    key_up();
    tick(10);
    drain();

    // Push and pop on the same edge while empty: the push lands.
    idx = $urandom_range(0, 7);
    key_down(idx);
    tick(D + 3);
    kif.KeyRead = 1'b1;
    tick(1);
    kif.KeyRead = 1'b0;
    model_push(idx);
    check_fifo("emptypp");
    key_up();
    tick(10);
    drain();
    pop();
    check_fifo("read_empty");

    // Randomized presses with occasional reads and overflow clears.
    for (int i = 0; i < 10; i++) begin
      press($urandom_range(0, 7), $urandom_range(10, 20));
      if ($urandom_range(0, 2) == 0) pop();
      if ($urandom_range(0, 3) == 0) begin
        ClrOvf = 1'b1;
        tick(1);
        ClrOvf = 1'b0;
        model_ovf = 1'b0;
      end
      check_fifo("rand");
    end

    // Async reset in the middle of a press with entries queued.
    drain();
    press(1, 12);
    press(4, 12);
    key_down(7);
    tick(4);
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    chk("rst.held", 32'(KeyHeld), 32'd0);
    check_fifo("rst.immediate");
    tick(2);
    rst_n = 1'b1;
    measure_valid(lat);
    chk("rst.repress_latency", lat, D + 3);
    model_push(7);
    check_fifo("rst.repress");
    key_up();
    tick(10);
    check_fifo("rst.final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
